multi_cycle_ctrl: RTL and testbench

Multi-cycle MIPS control unit. It sequences the shared datapath (one ALU, one unified memory, PC, IR and register file) through fetch, decode, execute, memory and writeback steps. Its `alu_op` output feeds the existing ALU control decoder unchanged: 00 = add, 01 = sub, 10 = decode funct. It stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multi_cycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Control unit for a multi-cycle MIPS datapath (shared ALU, unified memory,
//   PC, IR, register file). Steps through fetch / decode / execute / memory /
//   writeback. Stalls on mem_ready and counts retired instructions.
//
// State table (state | meaning):
//   INIT      (15) | after reset; all controls low
//   FETCH     (0)  | read instruction, PC <= PC+4 once memory is ready
//   DECODE    (1)  | read registers, precompute branch target
//   MEM_ADDR  (2)  | effective address for lw/sw
//   MEM_READ  (3)  | data read, wait for mem_ready
//   MEM_WB    (4)  | load data into register file
//   MEM_WRITE (5)  | data write, wait for mem_ready
//   EXECUTE   (6)  | R-type ALU operation
//   R_WB      (7)  | R-type result into rd
//   BRANCH    (8)  | beq compare, conditional PC update
//   JUMP      (9)  | PC <= jump target
//   ADDI_EX   (10) | rs + sign-extended immediate
//   ADDI_WB   (11) | addi result into rt
//   (12-14 unused; recover to FETCH)
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   opcode             IR[31:26], used in DECODE only
//   mem_ready          memory finished the current access
//   pc_write .. pc_source, alu_op   datapath controls
//   illegal            unsupported opcode decoded this cycle
//   state              current state (debug)
//   instr_count        retired instruction counter (wraps)
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_INIT      = 4'd15;
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic [5:0] op_q;
    logic       retire;

    assign state = state_q;

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_INIT:      state_nxt = S_FETCH;
            S_FETCH:     state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_nxt = S_EXECUTE;
                    OP_LW:    state_nxt = S_MEM_ADDR;
                    OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_BEQ:   state_nxt = S_BRANCH;
                    OP_J:     state_nxt = S_JUMP;
                    OP_ADDI:  state_nxt = S_ADDI_EX;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEM_ADDR, so anything other than lw is a store.
            S_MEM_ADDR:  state_nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WRITE: state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_nxt = S_R_WB;
            S_R_WB:      state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_ADDI_EX:   state_nxt = S_ADDI_WB;
            S_ADDI_WB:   state_nxt = S_FETCH;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        case (state_q)
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
            S_MEM_WRITE: retire = mem_ready;
            default:     retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            op_q        <= 6'd0;
            instr_count <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC load only on the cycle the instruction word arrives.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl
//   Drives instruction streams with random opcodes and memory stalls. The
//   reference is an instruction-level model: for each instruction it derives
//   the list of states the controller must walk through and the control word
//   expected in each, and keeps its own retired-instruction count.
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [3:0] INIT = 4'd15, FETCH = 4'd0, DECODE = 4'd1,
        MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4, MEM_WRITE = 4'd5,
        EXECUTE = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        ADDI_EX = 4'd10, ADDI_WB = 4'd11;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic             mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0]       alu_src_b, pc_source, alu_op;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
    //  ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op, illegal}
    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                   ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
                   alu_op, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] pack(input logic pw, pwc, iod, mr, mw, m2r, irw,
                                         rw, rd, asa, input logic [1:0] asb, pcs, aop,
                                         input logic ill);
        return {pw, pwc, iod, mr, mw, m2r, irw, rw, rd, asa, asb, pcs, aop, ill};
    endfunction

    // Control word the datapath needs in each step of the instruction walk.
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic rdy,
                                             input logic ill);
        case (st)
            FETCH:     return pack(rdy, 0, 0, 1, 0, 0, rdy, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            DECODE:    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill);
            MEM_ADDR:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            MEM_READ:  return pack(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            MEM_WB:    return pack(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            MEM_WRITE: return pack(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            EXECUTE:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0);
            R_WB:      return pack(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            BRANCH:    return pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            JUMP:      return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
            ADDI_EX:   return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            ADDI_WB:   return pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            default:   return 17'd0;
        endcase
    endfunction

    function automatic logic [5:0] rnd_op();
        logic [5:0] v;
        v = 6'($urandom_range(0, 63));
        return v;
    endfunction

    function automatic logic rbit();
        logic b;
        b = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic logic [5:0] op_for(input int kind);
        logic [5:0] v;
        case (kind)
            K_R:    v = 6'b000000;
            K_LW:   v = 6'b100011;
            K_SW:   v = 6'b101011;
            K_BEQ:  v = 6'b000100;
            K_J:    v = 6'b000010;
            K_ADDI: v = 6'b001000;
            default: begin
                v = rnd_op();
                while (v == 6'b000000 || v == 6'b100011 || v == 6'b101011 ||
                       v == 6'b000100 || v == 6'b000010 || v == 6'b001000)
                    v = rnd_op();
            end
        endcase
        return v;
    endfunction

    // Called just after a rising edge: drive inputs, check mid-cycle, advance.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                        input bit retire, input logic ill = 1'b0);
        mem_ready = rdy;
        opcode    = op;
        @(negedge clk);
        check("state", 32'(state), 32'(st));
        check("outs", 32'(outs), 32'(exp_outs(st, rdy, ill)));
        check("count", 32'(instr_count), 32'(exp_cnt));
        if (retire) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(posedge clk);
        #1;
    endtask

    // Runs one whole instruction, starting in FETCH.
    task automatic run_instr(input int kind, input int fst, input int mst);
        logic [5:0] op;
        op = op_for(kind);
        for (int i = 0; i < fst; i++) step(FETCH, 1'b0, rnd_op(), 0);
        step(FETCH, 1'b1, rnd_op(), 0);
        step(DECODE, rbit(), op, 0, (kind == K_ILL));
        case (kind)
            K_R: begin
                step(EXECUTE, rbit(), rnd_op(), 0);
                step(R_WB, rbit(), rnd_op(), 1);
            end
            K_LW: begin
                step(MEM_ADDR, rbit(), rnd_op(), 0);
                for (int i = 0; i < mst; i++) step(MEM_READ, 1'b0, rnd_op(), 0);
                step(MEM_READ, 1'b1, rnd_op(), 0);
                step(MEM_WB, rbit(), rnd_op(), 1);
            end
            K_SW: begin
                step(MEM_ADDR, rbit(), rnd_op(), 0);
                for (int i = 0; i < mst; i++) step(MEM_WRITE, 1'b0, rnd_op(), 0);
                step(MEM_WRITE, 1'b1, rnd_op(), 1);
            end
            K_BEQ:  step(BRANCH, rbit(), rnd_op(), 1);
            K_J:    step(JUMP, rbit(), rnd_op(), 1);
            K_ADDI: begin
                step(ADDI_EX, rbit(), rnd_op(), 0);
                step(ADDI_WB, rbit(), rnd_op(), 1);
            end
            default: ;
        endcase
    endtask

    // Asserts reset between edges, checks the async clear, releases it so the
    // next rising edge lands in FETCH.
    task automatic do_reset();
        mem_ready = 1'b1;
        rstn = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(INIT));
        check("rst_outs", 32'(outs), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'(INIT));
        check("rst_hold_outs", 32'(outs), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        check("init_state", 32'(state), 32'(INIT));
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // R-type, no stalls
        run_instr(K_R, 0, 0);
        // lw with two stalled read cycles
        run_instr(K_LW, 0, 2);
        // three-cycle fetch stall
        run_instr(K_R, 3, 0);
        // beq, j, sw, addi back to back
        run_instr(K_BEQ, 0, 0);
        run_instr(K_J, 0, 0);
        run_instr(K_SW, 0, 0);
        run_instr(K_ADDI, 0, 0);
        // illegal opcode 111111
        step(FETCH, 1'b1, rnd_op(), 0);
        step(DECODE, 1'b1, 6'b111111, 0, 1'b1);
        check("ill_cnt", 32'(instr_count), 32'(exp_cnt));

        // reset during a stalled store
        step(FETCH, 1'b1, rnd_op(), 0);
        step(DECODE, 1'b1, op_for(K_SW), 0);
        step(MEM_ADDR, 1'b1, rnd_op(), 0);
        step(MEM_WRITE, 1'b0, rnd_op(), 0);
        step(MEM_WRITE, 1'b0, rnd_op(), 0);
        do_reset();

        // sixteen retired instructions wrap a 4-bit counter back to zero
        for (int i = 0; i < 16; i++) run_instr(K_J, 0, 0);
        step(FETCH, 1'b1, rnd_op(), 0);
        step(DECODE, 1'b1, 6'b111111, 0, 1'b1);
        check("wrap", 32'(instr_count), 32'd0);

        // randomized instruction mix with random stalls
        for (int n = 0; n < 150; n++) begin
            int kind, fst, mst;
            kind = $urandom_range(0, 6);
            fst  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            mst  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(kind, fst, mst);
            if (n == 75) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
